// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the sequential ALU.
// Holds the 4-bit alucontrol operation codes (also used by the ALU control
// decoder) and the controller state type used by seq_alu.
// No ports: package only.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_MUL = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_FIN  = 2'b10
   } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if -- request/response bundle of the sequential ALU.
// Requester side: start, alucontrol, sign, a, b, shamt.
// Responder side: result, zero, busy, done, illegal.
// modport master : the requester (drives operands, observes results).
// modport slave  : the ALU itself.
interface seq_alu_if #(
   parameter int WIDTH = 32
) ();

   logic             start;
   logic [3:0]       alucontrol;
   logic             sign;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [4:0]       shamt;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             busy;
   logic             done;
   logic             illegal;

   modport master (
      output start, alucontrol, sign, a, b, shamt,
      input  result, zero, busy, done, illegal
   );

   modport slave (
      input  start, alucontrol, sign, a, b, shamt,
      output result, zero, busy, done, illegal
   );

endinterface

// File: rtl/mul_iter.sv
// mul_iter -- iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, reset : clock and synchronous active-high reset (aborts a run)
//   load       : capture a, b, sign and begin a new run
//   a, b, sign : operands; sign=1 treats them as two's complement
//   busy       : high while iterations remain
//   fin        : high in the cycle whose closing edge performs the last step
//   product    : low WIDTH bits of the product (valid once busy has dropped)
// Signed operands are reduced to magnitudes at load; the sign of the result is
// reapplied on the output, which gives the same low WIDTH bits as a true
// two's-complement multiply.
module mul_iter #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sign,
   output logic             busy,
   output logic             fin,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(MUL_CYCLES + 1);

   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] mplier_r;
   logic [WIDTH-1:0] acc_r;
   logic             neg_r;
   logic             busy_r;
   logic [CW-1:0]    count_r;
   logic             last_s;

   // Absolute value when the operand is signed and negative.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic s);
      magnitude = (s && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
   endfunction

   assign last_s  = busy_r && (count_r == CW'(MUL_CYCLES - 1));
   assign busy    = busy_r;
   assign fin     = last_s;
   assign product = neg_r ? ({WIDTH{1'b0}} - acc_r) : acc_r;

   // Operand capture and one shift-add step per cycle while busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_r  <= {WIDTH{1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
         neg_r    <= 1'b0;
         busy_r   <= 1'b0;
         count_r  <= {CW{1'b0}};
      end else if (load) begin
         mcand_r  <= magnitude(a, sign);
         mplier_r <= magnitude(b, sign);
         acc_r    <= {WIDTH{1'b0}};
         neg_r    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
         busy_r   <= 1'b1;
         count_r  <= {CW{1'b0}};
      end else if (busy_r) begin
         if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
         end else begin
            acc_r <= acc_r;
         end
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_r >> 1;
         count_r  <= count_r + CW'(1);
         busy_r   <= ~last_s;
      end else begin
         busy_r <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// seq_alu -- sequential ALU: single-cycle logic/arith ops plus an iterative
// multiply handled by mul_iter.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset; aborts a multiply without done
//   bus   : seq_alu_if slave (start/alucontrol/sign/a/b/shamt in,
//           result/zero/busy/done/illegal out)
// Non-multiply ops complete one cycle after start. A multiply runs for
// MUL_CYCLES steps, passes through FIN and reports on the following edge.
// start is only looked at in IDLE, so requests during a multiply are dropped.
// MUL_CYCLES must equal WIDTH.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset,
   seq_alu_if.slave   bus
);

   state_t           state_r;
   state_t           next_state_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             legal_s;
   logic             lt_s;
   logic             mul_load_s;
   logic             upd_s;
   logic             ill_s;
   logic [WIDTH-1:0] nxt_result_s;
   logic             mul_busy_s;
   logic             mul_fin_s;
   logic [WIDTH-1:0] mul_prod_s;
   logic [WIDTH-1:0] result_r;
   logic             zero_r;
   logic             done_r;
   logic             illegal_r;

   mul_iter #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .load    (mul_load_s),
      .a       (bus.a),
      .b       (bus.b),
      .sign    (bus.sign),
      .busy    (mul_busy_s),
      .fin     (mul_fin_s),
      .product (mul_prod_s)
   );

   // Single-cycle datapath; unknown codes yield zero and clear legal_s.
   always_comb begin
      alu_res_s = {WIDTH{1'b0}};
      legal_s   = 1'b1;
      if (bus.sign) begin
         lt_s = $signed(bus.a) < $signed(bus.b);
      end else begin
         lt_s = bus.a < bus.b;
      end
      case (bus.alucontrol)
         ALU_AND: alu_res_s = bus.a & bus.b;
         ALU_OR:  alu_res_s = bus.a | bus.b;
         ALU_ADD: alu_res_s = bus.a + bus.b;
         ALU_SLL: alu_res_s = bus.b << bus.shamt;
         ALU_SUB: alu_res_s = bus.a - bus.b;
         ALU_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, lt_s};
         ALU_NOR: alu_res_s = ~(bus.a | bus.b);
         ALU_MUL: alu_res_s = {WIDTH{1'b0}};
         default: legal_s   = 1'b0;
      endcase
   end

   // Next state, multiplier load and the value to register on completion.
   always_comb begin
      next_state_s = state_r;
      mul_load_s   = 1'b0;
      upd_s        = 1'b0;
      ill_s        = 1'b0;
      nxt_result_s = {WIDTH{1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (bus.start && (bus.alucontrol == ALU_MUL)) begin
               next_state_s = ST_MUL;
               mul_load_s   = 1'b1;
            end else if (bus.start) begin
               upd_s        = 1'b1;
               ill_s        = ~legal_s;
               nxt_result_s = alu_res_s;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (mul_fin_s) begin
               next_state_s = ST_FIN;
            end else begin
               next_state_s = ST_MUL;
            end
         end
         ST_FIN: begin
            next_state_s = ST_IDLE;
            upd_s        = 1'b1;
            nxt_result_s = mul_prod_s;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers; result/zero hold between done pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         result_r  <= {WIDTH{1'b0}};
         zero_r    <= 1'b1;
         done_r    <= 1'b0;
         illegal_r <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         done_r    <= upd_s;
         illegal_r <= upd_s & ill_s;
         if (upd_s) begin
            result_r <= nxt_result_s;
            zero_r   <= (nxt_result_s == {WIDTH{1'b0}});
         end else begin
            result_r <= result_r;
            zero_r   <= zero_r;
         end
      end
   end

   assign bus.result  = result_r;
   assign bus.zero    = zero_r;
   assign bus.busy    = mul_busy_s;
   assign bus.done    = done_r;
   assign bus.illegal = illegal_r;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu -- scoreboard bench for seq_alu with directed vectors.
module tb_seq_alu;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(32)) bus ();

   seq_alu #(.WIDTH(32), .MUL_CYCLES(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ill;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expectation and its cycle.
   always @(negedge clk) begin
      exp_t e;
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: result %h at cyc %0d, none expected", bus.result, cyc);
         end else begin
            e = sb.pop_front();
            total++;
            if (bus.result !== e.res || bus.zero !== e.zero || bus.illegal !== e.ill || cyc != e.due) begin
               bad++;
               $display("FAIL response: got res=%h zero=%b ill=%b cyc=%0d want res=%h zero=%b ill=%b cyc=%0d",
                        bus.result, bus.zero, bus.illegal, cyc, e.res, e.zero, e.ill, e.due);
            end
         end
      end else if (cyc > 0 && bus.illegal !== 1'b0) begin
         total++;
         bad++;
         $display("FAIL stray_illegal: illegal=%b without done at cyc %0d", bus.illegal, cyc);
      end
   end

   task automatic drive(input logic [3:0] op, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] sh);
      bus.alucontrol = op;
      bus.sign       = s;
      bus.a          = av;
      bus.b          = bv;
      bus.shamt      = sh;
   endtask

   // Single-cycle op; called just after a rising edge.
   task automatic issue(input logic [3:0] op, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] sh,
                        input logic [31:0] er, input logic ei);
      drive(op, s, av, bv, sh);
      bus.start = 1'b1;
      sb.push_back('{er, (er == 32'h0), ei, cyc + 1});
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Multiply with a competing start and operand changes mid-run.
   task automatic mul_run(input logic s, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] er);
      int busy_cnt;
      busy_cnt = 0;
      drive(ALU_MUL, s, av, bv, 5'd0);
      bus.start = 1'b1;
      sb.push_back('{er, (er == 32'h0), 1'b0, cyc + 34});
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) busy_cnt++;
         if (i == 10) begin
            drive(ALU_ADD, ~s, 32'h0000_0001, 32'h0000_0001, 5'd3);
            bus.start = 1'b1;
         end
         if (i == 11) begin
            bus.start = 1'b0;
            drive(ALU_MUL, s, 32'h1234_5678, 32'h0BAD_F00D, 5'd0);
         end
      end
      chk("mul_busy_cycles", 32'(busy_cnt), 32'd32);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      bus.start = 1'b1;
      drive(ALU_ADD, 1'b0, 32'd2, 32'd3, 5'd0);

      // Reset dominates a simultaneous start.
      @(posedge clk);
      @(negedge clk);
      chk("rst_result",  bus.result,         32'h0);
      chk("rst_zero",    32'(bus.zero),      32'd1);
      chk("rst_busy",    32'(bus.busy),      32'd0);
      chk("rst_done",    32'(bus.done),      32'd0);
      chk("rst_illegal", 32'(bus.illegal),   32'd0);
      @(posedge clk);
      #1;
      // First edge with reset low accepts the pending start.
      reset = 1'b0;
      sb.push_back('{32'd5, 1'b0, 1'b0, cyc + 1});
      @(posedge clk);
      #1 bus.start = 1'b0;

      issue(ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b0);
      issue(ALU_SUB, 1'b0, 32'd5,         32'd5,         5'd0, 32'h0000_0000, 1'b0);
      issue(ALU_SLT, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0001, 1'b0);
      issue(ALU_SLT, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b0);
      issue(ALU_SLT, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b0);
      issue(ALU_SLT, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0, 32'h0000_0001, 1'b0);
      issue(ALU_AND, 1'b0, 32'hF0F0_FFFF, 32'h0FF0_F00F, 5'd0, 32'h00F0_F00F, 1'b0);
      issue(ALU_OR,  1'b0, 32'h0F00_0000, 32'h0000_00F0, 5'd0, 32'h0F00_00F0, 1'b0);
      issue(ALU_NOR, 1'b0, 32'h0F0F_0000, 32'hF0F0_0000, 5'd0, 32'h0000_FFFF, 1'b0);
      issue(ALU_NOR, 1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd0, 32'h0000_0000, 1'b0);
      issue(ALU_ADD, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b0);
      issue(ALU_SUB, 1'b0, 32'h0000_0000, 32'h0000_0001, 5'd0, 32'hFFFF_FFFF, 1'b0);
      issue(4'b0101, 1'b0, 32'd12,        32'd34,        5'd0, 32'h0000_0000, 1'b1);
      issue(ALU_SLL, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
      issue(4'b1010, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b1);
      issue(ALU_SLL, 1'b0, 32'h0000_0000, 32'h0000_0003, 5'd4, 32'h0000_0030, 1'b0);

      // Result and zero hold after done.
      repeat (3) @(posedge clk);
      #1;
      chk("hold_result", bus.result,    32'h0000_0030);
      chk("hold_zero",   32'(bus.zero), 32'd0);

      mul_run(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB);
      mul_run(1'b0, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A);
      mul_run(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0000_0014);
      mul_run(1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
      mul_run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

      // Reset aborts an in-flight multiply with no done.
      drive(ALU_MUL, 1'b0, 32'd6, 32'd7, 5'd0);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (13) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("abort_result",  bus.result,       32'h0);
      chk("abort_zero",    32'(bus.zero),    32'd1);
      chk("abort_busy",    32'(bus.busy),    32'd0);
      chk("abort_done",    32'(bus.done),    32'd0);
      chk("abort_illegal", 32'(bus.illegal), 32'd0);
      issue(ALU_ADD, 1'b0, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      chk("after_abort_result", bus.result, 32'd2);
      chk("after_abort_busy",   32'(bus.busy), 32'd0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width.
REQ-002 Parameter MUL_CYCLES, default 32, multiply iteration count; SHALL equal WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request strobe, sampled only in IDLE.
REQ-006 alucontrol  input  4  operation code, from the ALU control decoder.
REQ-007 sign  input  1  1 = signed SLT/MUL, 0 = unsigned.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B; this is the shifted operand for SLL.
REQ-010 shamt  input  5  shift amount for SLL.
REQ-011 result  output  WIDTH  registered result, held until the next done.
REQ-012 zero  output  1  registered, (result == 0).
REQ-013 busy  output  1  high while a multiply is in progress.
REQ-014 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-015 illegal  output  1  one-cycle pulse coincident with done for an unknown code.

Function
REQ-016 Codes SHALL be: AND=0000, OR=0001, ADD=0010, SLL=0011, SUB=0110, SLT=0111, NOR=1100, MUL=1111.
REQ-017 FSM states SHALL be IDLE, MUL, FIN.
- IDLE->MUL on start with MUL.
- MUL->FIN after MUL_CYCLES iterations.
- FIN->IDLE unconditionally.
REQ-018 Non-MUL op: start sampled at edge N SHALL give result, zero and done=1 after edge N; FSM stays in IDLE.
REQ-019 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-020 SLL SHALL yield b << shamt, zero-filled.
REQ-021 SLT SHALL yield 1 if a<b, else 0; signed compare when sign=1, unsigned when sign=0.
REQ-022 MUL SHALL latch a, b and sign at start, then do one shift-add step per cycle.
- busy=1 from edge N+1 through the last iteration.
- FIN is entered after edge N+MUL_CYCLES.
- done, result and zero are registered at edge N+MUL_CYCLES+1; latency is 33 cycles for WIDTH=32.
REQ-023 MUL result SHALL be the low WIDTH bits of the product.
- sign=1: multiply magnitudes, then negate the product if the operand signs differ.
- sign=0: unsigned product.
REQ-024 start while busy or in FIN SHALL be ignored, with no queuing and no effect on the running multiply.
REQ-025 Changes to a, b, alucontrol or sign during MUL SHALL not affect the result.
REQ-026 An unknown code SHALL give result=0, zero=1, done=1 and illegal=1, all one cycle after start.
REQ-027 done and illegal SHALL be low in every cycle not named above.
REQ-028 result and zero SHALL hold their values between done pulses.

Reset
REQ-029 reset=1 at any edge SHALL force IDLE, result=0, zero=1, busy=0, done=0, illegal=0.
REQ-030 reset SHALL take priority over start and SHALL abort an in-flight multiply with no done pulse.
REQ-031 First start SHALL be accepted at the first edge with reset=0.

Structure
REQ-032 Package alu_pkg SHALL hold the alucontrol code constants and the FSM state type; the ALU control decoder shares these codes.
REQ-033 The iterative multiplier SHALL be sub-module mul_iter.
- Ports: clk, reset, load, a, b, sign, busy, fin, product.
- seq_alu owns the FSM and output registers.

Verification
REQ-034 ADD a=0x7FFFFFFF, b=1 -> after 1 cycle: result=0x80000000, done=1, zero=0.
REQ-035 SUB a=5, b=5 -> result=0, zero=1; SLT sign=1, a=0xFFFFFFFF, b=1 -> 1; same with sign=0 -> 0.
REQ-036 MUL sign=1, a=-3, b=7 -> busy for 32 cycles; result=0xFFFFFFEB with done at cycle 33; second start issued at cycle 10 is ignored.
REQ-037 MUL a=6, b=7; reset at cycle 15 -> no done; outputs at reset values; an ADD 1+1 next cycle gives 2.
REQ-038 alucontrol=0101 -> illegal=1, done=1, result=0 after 1 cycle; SLL b=1, shamt=31 -> 0x80000000.
